// File: rtl/i2c_ctrl_pkg.sv
// Shared opcodes, response codes and FSM encodings for the I2C master controller.
package i2c_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        STS_OK       = 2'd0,
        STS_NACK     = 2'd1,
        STS_ARB_LOST = 2'd2,
        STS_ILLEGAL  = 2'd3
    } status_e;

    typedef logic [2:0] state_e;

    localparam state_e S_IDLE  = 3'd0;
    localparam state_e S_HOLD  = 3'd1;
    localparam state_e S_START = 3'd2;
    localparam state_e S_XFER  = 3'd3;
    localparam state_e S_STOP  = 3'd4;

    localparam int         BITS_PER_FRAME = 9;
    localparam logic [3:0] LAST_BIT       = 4'(BITS_PER_FRAME - 1);

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL quarter-period timer: CLK_DIV cycles per quarter, restartable at any quarter.
// Freezes (no progress, no strobe) while freeze is high; last is a single-cycle end-of-quarter strobe.
module i2c_quarter_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic       system_clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] start_quarter,
    input  logic       freeze,
    output logic [1:0] quarter,
    output logic       last
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign last = ~start & ~freeze & (cnt == CNT_MAX);

    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            cnt     <= '0;
            quarter <= 2'd0;
        end else if (start) begin
            cnt     <= '0;
            quarter <= start_quarter;
        end else if (!freeze) begin
            if (cnt == CNT_MAX) begin
                cnt     <= '0;
                quarter <= quarter + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Command-driven I2C master: START/WRITE/READ/STOP over valid/ready, one response pulse per command.
// Latency 2*, 4* or 36*CLK_DIV cycles plus clock stretching; cmd_ready only in IDLE/HOLD, no response backpressure.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       system_clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_status,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    import i2c_ctrl_pkg::*;

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $fatal(1, "i2c_master_ctrl: CLK_DIV must be >= 2");
    end

    state_e     state;
    logic [3:0] bit_idx;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       is_read;
    logic       nack_bit;
    logic       ack_smp;

    logic [1:0] quarter;
    logic       q_last;
    logic       cmd_fire;
    logic       tmr_start;
    logic [1:0] start_quarter;
    logic       freeze;
    logic       last_bit;
    logic       bit_drive;
    logic       arb_lost;

    assign cmd_ready = (state == S_IDLE) || (state == S_HOLD);
    assign busy      = (state != S_IDLE);
    assign cmd_fire  = cmd_valid & cmd_ready;

    // Non-START commands in IDLE are rejected without touching the bus.
    assign tmr_start     = cmd_fire & ~((state == S_IDLE) & (cmd_op != OP_START));
    assign start_quarter = (state == S_IDLE) ? 2'd2 : 2'd0;
    assign freeze        = ~scl_oe & ~scl_in;
    assign last_bit      = (bit_idx == LAST_BIT);
    assign arb_lost      = ~is_read & ~last_bit & tx_sr[7] & ~sda_in;

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_qtimer (
        .system_clock  (system_clock),
        .reset_n       (reset_n),
        .start         (tmr_start),
        .start_quarter (start_quarter),
        .freeze        (freeze),
        .quarter       (quarter),
        .last          (q_last)
    );

    always_comb begin
        bit_drive = 1'b0;
        if (is_read) begin
            bit_drive = last_bit & ~nack_bit;
        end else begin
            bit_drive = ~last_bit & ~tx_sr[7];
        end
    end

    // Line drives are decoded from registered state/quarter, so a state change releases both lines at once.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            S_HOLD: begin
                scl_oe = 1'b1;
            end
            S_START: begin
                scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
                sda_oe = quarter[1];
            end
            S_XFER: begin
                scl_oe = ~quarter[1];
                sda_oe = bit_drive;
            end
            S_STOP: begin
                scl_oe = (quarter == 2'd0);
                sda_oe = ~quarter[1];
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            bit_idx    <= 4'd0;
            tx_sr      <= 8'd0;
            rx_sr      <= 8'd0;
            is_read    <= 1'b0;
            nack_bit   <= 1'b0;
            ack_smp    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'd0;
            rsp_status <= STS_OK;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_op == OP_START) begin
                            state <= S_START;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_data   <= 8'd0;
                            rsp_status <= STS_ILLEGAL;
                        end
                    end
                end
                S_HOLD: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_START: state <= S_START;
                            OP_STOP:  state <= S_STOP;
                            default: begin
                                state    <= S_XFER;
                                is_read  <= (cmd_op == OP_READ);
                                tx_sr    <= cmd_data;
                                nack_bit <= cmd_nack;
                                bit_idx  <= 4'd0;
                            end
                        endcase
                    end
                end
                S_START: begin
                    if (q_last && quarter == 2'd3) begin
                        state      <= S_HOLD;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= 8'd0;
                        rsp_status <= STS_OK;
                    end
                end
                S_STOP: begin
                    if (q_last && quarter == 2'd3) begin
                        state      <= S_IDLE;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= 8'd0;
                        rsp_status <= STS_OK;
                    end
                end
                S_XFER: begin
                    if (q_last && quarter == 2'd2) begin
                        if (arb_lost) begin
                            state      <= S_IDLE;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= 8'd0;
                            rsp_status <= STS_ARB_LOST;
                        end else if (last_bit) begin
                            ack_smp <= sda_in;
                        end else if (is_read) begin
                            rx_sr <= {rx_sr[6:0], sda_in};
                        end
                    end
                    if (q_last && quarter == 2'd3) begin
                        if (last_bit) begin
                            state      <= S_HOLD;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= is_read ? rx_sr : 8'd0;
                            rsp_status <= (!is_read && ack_smp) ? STS_NACK : STS_OK;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
